// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = XLEN;
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned ACC_W = 2 * XLEN;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle for the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    op_e             op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wd;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the 64-bit accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [XLEN-1:0]  i_operand,
    input  logic             i_div,
    output logic [ACC_W-1:0] o_acc_c
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shift_rem;
    logic [XLEN:0] w_trial;

    // Multiply keeps the 33-bit carry on the right shift; divide keeps a 33-bit trial remainder.
    always_comb begin
        w_sum       = {1'b0, i_acc[ACC_W-1:XLEN]} + {1'b0, i_operand};
        w_shift_rem = i_acc[ACC_W-1:XLEN-1];
        w_trial     = w_shift_rem - {1'b0, i_operand};
        o_acc_c     = i_acc;
        if (i_div) begin
            if (!w_trial[XLEN]) begin
                o_acc_c = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc_c = {w_shift_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end else if (i_acc[0]) begin
            o_acc_c = {w_sum, i_acc[XLEN-1:1]};
        end else begin
            o_acc_c = {1'b0, i_acc[ACC_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    muldiv_if.slave bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic [XLEN-1:0]  r_a_orig;
    logic [XLEN-1:0]  r_operand;
    logic [ACC_W-1:0] r_acc;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_signed;
    logic             w_is_div;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_prod;
    logic [XLEN-1:0]  w_res_hi;
    logic [XLEN-1:0]  w_res_lo;

    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_a_mag  = magnitude(bus.a, w_signed);
    assign w_b_mag  = magnitude(bus.b, w_signed);

    muldiv_step u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_div     (r_div),
        .o_acc_c   (w_acc_next)
    );

    // Sign correction and divide-by-zero override applied on the way into HI/LO.
    always_comb begin
        w_prod   = r_neg_res ? ACC_W'(-r_acc) : r_acc;
        w_res_hi = w_prod[ACC_W-1:XLEN];
        w_res_lo = w_prod[XLEN-1:0];
        if (r_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a_orig;
                w_res_lo = '1;
            end else begin
                w_res_lo = r_neg_res ? XLEN'(-r_acc[XLEN-1:0])     : r_acc[XLEN-1:0];
                w_res_hi = r_neg_rem ? XLEN'(-r_acc[ACC_W-1:XLEN]) : r_acc[ACC_W-1:XLEN];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_orig  <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wd;
                    if (bus.lo_we) r_lo <= bus.wd;
                    if (bus.start) begin
                        r_state   <= S_CALC;
                        r_busy    <= 1'b1;
                        r_count   <= '0;
                        r_div     <= w_is_div;
                        r_neg_res <= w_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                        r_neg_rem <= w_signed && bus.a[XLEN-1];
                        r_b_zero  <= (bus.b == '0);
                        r_a_orig  <= bus.a;
                        // Low half holds the multiplier (multiply) or the dividend (divide).
                        r_acc     <= {XLEN'(0), w_is_div ? w_a_mag : w_b_mag};
                        r_operand <= w_is_div ? w_b_mag : w_a_mag;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(ITER - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
